rp_dv_sched: RTL and testbench

RP_DV_SCHED -- requirements
Module: rp_dv_sched

---
 rtl/rp_dv_pkg.sv | 16 +
 rtl/rp_dv_sched_if.sv | 31 +++
 rtl/rp_dv_dec.sv | 73 +++++++
 rtl/rp_dv_sched.sv | 159 +++++++++++++++
 tb/tb_rp_dv_sched.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rp_dv_pkg.sv
// rp_dv_pkg: shared types and default widths for the ADC data-valid scheduler.
package rp_dv_pkg;

    // Default decimation counter width and sample length/count width.
    localparam int DEF_CW = 17;
    localparam int DEF_NW = 32;

    // Scheduler run states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : rp_dv_pkg

// File: rtl/rp_dv_sched_if.sv
// rp_dv_sched_if: bundle of the scheduler's data-valid, control and status
// signals. The master side drives stimulus/config, the slave side is the
// scheduler itself.
interface rp_dv_sched_if
    import rp_dv_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int NW = DEF_NW
);
    logic          adc_dv;
    logic          cfg_chop;
    logic [CW-1:0] cfg_dec;
    logic [NW-1:0] cfg_len;
    logic          start;
    logic          stop;
    logic          trig;
    logic          dv_out;
    logic          busy;
    logic          done;
    logic [NW-1:0] cnt;

    modport master (
        output adc_dv, cfg_chop, cfg_dec, cfg_len, start, stop, trig,
        input  dv_out, busy, done, cnt
    );

    modport slave (
        input  adc_dv, cfg_chop, cfg_dec, cfg_len, start, stop, trig,
        output dv_out, busy, done, cnt
    );
endinterface : rp_dv_sched_if

// File: rtl/rp_dv_dec.sv
// rp_dv_dec: chop qualification and modulo-dec counting of raw ADC valids.
// hit_o is combinational: it flags the adc_dv_i that completes a decimation
// period, so the scheduler can register it as the outgoing sample pulse.
module rp_dv_dec
    import rp_dv_pkg::*;
#(
    parameter int CW = DEF_CW
)
(
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          dv_i,
    input  logic          chop_i,
    input  logic [CW-1:0] dec_i,
    output logic          hit_o
);

    logic          phase_q;
    logic          phase_d;
    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic [CW-1:0] dec_last_s;
    logic          qual_s;

    // Qualify valids, detect the terminal count and compute next phase/count.
    always_comb begin
        // A ratio of 0 behaves like 1: every qualified valid terminates.
        if (dec_i == {CW{1'b0}}) begin
            dec_last_s = {CW{1'b0}};
        end else begin
            dec_last_s = dec_i - {{(CW-1){1'b0}}, 1'b1};
        end
        // With chop, only the valid seen while phase is 1 passes.
        qual_s = en_i & dv_i & (~chop_i | phase_q);
        hit_o  = qual_s & (div_q == dec_last_s);
        phase_d = phase_q;
        div_d   = div_q;
        if (clr_i) begin
            phase_d = 1'b0;
            div_d   = {CW{1'b0}};
        end else if (en_i && dv_i) begin
            if (chop_i) begin
                phase_d = ~phase_q;
            end else begin
                phase_d = phase_q;
            end
            if (hit_o) begin
                div_d = {CW{1'b0}};
            end else if (qual_s) begin
                div_d = div_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                div_d = div_q;
            end
        end else begin
            phase_d = phase_q;
            div_d   = div_q;
        end
    end

    // Hold chop phase and decimation count between valids.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= 1'b0;
            div_q   <= {CW{1'b0}};
        end else begin
            phase_q <= phase_d;
            div_q   <= div_d;
        end
    end

endmodule : rp_dv_dec

// File: rtl/rp_dv_sched.sv
// rp_dv_sched: schedules decimated/chopped ADC data-valid pulses over runs
// of cfg_len samples (0 = continuous) between start_i and stop_i.
// Optional macro RP_DV_SCHED_TRIG_EN adds trig_i and an ARM state that holds
// a started run until the trigger arrives.
module rp_dv_sched
    import rp_dv_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int NW = DEF_NW
)
(
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          adc_dv_i,
    input  logic          cfg_chop_i,
    input  logic [CW-1:0] cfg_dec_i,
    input  logic [NW-1:0] cfg_len_i,
    input  logic          start_i,
    input  logic          stop_i,
`ifdef RP_DV_SCHED_TRIG_EN
    input  logic          trig_i,
`endif
    output logic          adc_dv_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [NW-1:0] cnt_o
);

`ifdef RP_DV_SCHED_TRIG_EN
    localparam state_e START_STATE = ST_ARM;
`else
    localparam state_e START_STATE = ST_RUN;
`endif

    state_e        state_q;
    logic          chop_q;
    logic [CW-1:0] dec_q;
    logic [NW-1:0] len_q;
    logic [NW-1:0] cnt_q;
    logic          dv_q;
    logic          busy_q;
    logic          done_q;

    logic [NW-1:0] cnt_inc_s;
    logic          finished_s;
    logic          last_s;
    logic          dec_en_s;
    logic          dec_clr_s;
    logic          hit_s;

    // Run bookkeeping: final-sample detection and decimator enable/clear.
    always_comb begin
        cnt_inc_s  = cnt_q + {{(NW-1){1'b0}}, 1'b1};
        // cnt only reaches len through an emitted pulse, so this is the
        // cycle in which the last sample is on adc_dv_o.
        finished_s = (len_q != {NW{1'b0}}) && (cnt_q == len_q);
        last_s     = hit_s && (len_q != {NW{1'b0}}) && (cnt_inc_s == len_q);
        dec_clr_s  = (state_q == ST_IDLE) && start_i;
`ifdef RP_DV_SCHED_TRIG_EN
        dec_en_s   = ((state_q == ST_RUN) && !finished_s) ||
                     ((state_q == ST_ARM) && trig_i && !stop_i);
`else
        dec_en_s   = (state_q == ST_RUN) && !finished_s;
`endif
    end

    rp_dv_dec #(.CW(CW)) u_dec (
        .clk_i   (adc_clk_i),
        .rst_n_i (adc_rstn_i),
        .clr_i   (dec_clr_s),
        .en_i    (dec_en_s),
        .dv_i    (adc_dv_i),
        .chop_i  (chop_q),
        .dec_i   (dec_q),
        .hit_o   (hit_s)
    );

    // Run-control FSM with registered valid, busy, done and count outputs.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q <= ST_IDLE;
            chop_q  <= 1'b0;
            dec_q   <= {CW{1'b0}};
            len_q   <= {NW{1'b0}};
            cnt_q   <= {NW{1'b0}};
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= START_STATE;
                        chop_q  <= cfg_chop_i;
                        dec_q   <= cfg_dec_i;
                        len_q   <= cfg_len_i;
                        cnt_q   <= {NW{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
`ifdef RP_DV_SCHED_TRIG_EN
                ST_ARM: begin
                    if (stop_i) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (trig_i) begin
                        state_q <= ST_RUN;
                        if (hit_s) begin
                            dv_q  <= 1'b1;
                            cnt_q <= cnt_inc_s;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end else begin
                        state_q <= ST_ARM;
                    end
                end
`endif
                ST_RUN: begin
                    if (finished_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (last_s) begin
                        // The final sample wins over a coincident stop; the
                        // finished check closes the run on the next cycle.
                        dv_q  <= 1'b1;
                        cnt_q <= cnt_inc_s;
                    end else if (stop_i) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (hit_s) begin
                        dv_q  <= 1'b1;
                        cnt_q <= cnt_inc_s;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_dv_o = dv_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign cnt_o    = cnt_q;

endmodule : rp_dv_sched

// File: tb/tb_rp_dv_sched.sv
// tb_rp_dv_sched: scoreboard bench for rp_dv_sched. A reference model that
// reasons in counts (valids seen, qualified valids, samples emitted) predicts
// each adc_dv_o / done_o pulse; a negedge monitor pops and compares.
// Build with RP_DV_SCHED_TRIG_EN defined to also exercise the trigger path.
module tb_rp_dv_sched;
    import rp_dv_pkg::*;

    localparam int CW = DEF_CW;
    localparam int NW = DEF_NW;
`ifdef RP_DV_SCHED_TRIG_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rp_dv_sched_if #(.CW(CW), .NW(NW)) bus();

    always #5 clk = ~clk;

    rp_dv_sched #(.CW(CW), .NW(NW)) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rst_n),
        .adc_dv_i   (bus.adc_dv),
        .cfg_chop_i (bus.cfg_chop),
        .cfg_dec_i  (bus.cfg_dec),
        .cfg_len_i  (bus.cfg_len),
        .start_i    (bus.start),
        .stop_i     (bus.stop),
`ifdef RP_DV_SCHED_TRIG_EN
        .trig_i     (bus.trig),
`endif
        .adc_dv_o   (bus.dv_out),
        .busy_o     (bus.busy),
        .done_o     (bus.done),
        .cnt_o      (bus.cnt)
    );

    typedef struct {
        int            cyc;
        logic [NW-1:0] cnt;
    } ev_t;

    ev_t           exp_dv[$];
    ev_t           exp_done[$];
    bit            exp_busy[int];
    logic [NW-1:0] exp_cnt[int];

    int cyc         = 0;
    int n_cmp       = 0;
    int n_err       = 0;
    int n_dv_seen   = 0;
    int n_done_seen = 0;

    // Reference model: 0 idle, 1 armed, 2 running, 3 done.
    int            m_state = 0;
    int            m_vseen = 0;
    int            m_qual  = 0;
    int            m_dec   = 1;
    bit            m_chop  = 1'b0;
    logic [NW-1:0] m_cnt   = '0;
    logic [NW-1:0] m_len   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One raw valid during a run: returns 1 when it completes a decimation period.
    function automatic bit take_valid(input bit dv);
        if (!dv) return 1'b0;
        m_vseen++;
        if (m_chop && (m_vseen % 2 == 1)) return 1'b0;
        m_qual++;
        return (m_qual % m_dec) == 0;
    endfunction

    // Advance the model over one clock edge with the inputs present at that edge.
    task automatic model_step(input bit dv, input bit st, input bit sp, input bit tg);
        bit            hit;
        bit            emit;
        bit            to_done;
        logic [NW-1:0] nxt;
        hit = 1'b0; emit = 1'b0; to_done = 1'b0;
        case (m_state)
            0: if (st) begin
                m_chop  = bus.cfg_chop;
                m_dec   = (bus.cfg_dec == '0) ? 1 : int'(bus.cfg_dec);
                m_len   = bus.cfg_len;
                m_cnt   = '0;
                m_vseen = 0;
                m_qual  = 0;
                m_state = TRIG ? 1 : 2;
            end
            1: if (sp) begin
                to_done = 1'b1;
            end else if (tg) begin
                m_state = 2;
                emit = take_valid(dv);
            end
            2: begin
                nxt = m_cnt + 1;
                if (m_len != '0 && m_cnt == m_len) begin
                    to_done = 1'b1;
                end else begin
                    hit = take_valid(dv);
                    if (hit && m_len != '0 && nxt == m_len) emit = 1'b1;
                    else if (sp) to_done = 1'b1;
                    else emit = hit;
                end
            end
            default: m_state = 0;
        endcase
        if (emit) begin
            m_cnt = m_cnt + 1;
            exp_dv.push_back('{cyc: cyc, cnt: m_cnt});
        end
        if (to_done) begin
            m_state = 3;
            exp_done.push_back('{cyc: cyc, cnt: m_cnt});
        end
        exp_busy[cyc] = (m_state != 0);
        exp_cnt[cyc]  = m_cnt;
    endtask

    task automatic tick(input bit dv, input bit st, input bit sp, input bit tg);
        bus.adc_dv = dv;
        bus.start  = st;
        bus.stop   = sp;
        bus.trig   = tg;
        @(posedge clk);
        cyc++;
        model_step(dv, st, sp, tg);
        @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit chop, input int dec, input int len);
        bus.cfg_chop = chop;
        bus.cfg_dec  = CW'(dec);
        bus.cfg_len  = NW'(len);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_dv"},   bus.dv_out, 0);
        chk({tag, "_busy"}, bus.busy,   0);
        chk({tag, "_done"}, bus.done,   0);
        chk({tag, "_cnt"},  bus.cnt,    0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_async");
        m_state = 0;
        m_cnt   = '0;
        exp_dv.delete();
        exp_done.delete();
        @(posedge clk);
        cyc++;
        exp_busy[cyc] = 1'b0;
        exp_cnt[cyc]  = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare per-cycle status and pop expected pulse events.
    always @(negedge clk) begin
        if (exp_busy.exists(cyc)) begin
            chk("busy", bus.busy, exp_busy[cyc]);
            chk("cnt",  bus.cnt,  exp_cnt[cyc]);
        end
        while (exp_dv.size() > 0 && exp_dv[0].cyc < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL dv_missing: adc_dv_o 0 at cycle %0d, required 1 (sample %0d)", exp_dv[0].cyc, exp_dv[0].cnt);
            void'(exp_dv.pop_front());
        end
        if (bus.dv_out !== 1'b0) begin
            n_dv_seen++;
            if (exp_dv.size() == 0 || exp_dv[0].cyc != cyc) begin
                n_cmp++; n_err++;
                $display("FAIL dv_unexpected: adc_dv_o %b at cycle %0d, required 0", bus.dv_out, cyc);
            end else begin
                chk("dv_cnt", bus.cnt, exp_dv[0].cnt);
                void'(exp_dv.pop_front());
            end
        end
        while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
            n_cmp++; n_err++;
            $display("FAIL done_missing: done_o 0 at cycle %0d, required 1", exp_done[0].cyc);
            void'(exp_done.pop_front());
        end
        if (bus.done !== 1'b0) begin
            n_done_seen++;
            if (exp_done.size() == 0 || exp_done[0].cyc != cyc) begin
                n_cmp++; n_err++;
                $display("FAIL done_unexpected: done_o %b at cycle %0d, required 0", bus.done, cyc);
            end else begin
                chk("done_cnt", bus.cnt, exp_done[0].cnt);
                void'(exp_done.pop_front());
            end
        end
    end

    initial begin
        int d0;
        int dn0;
        bus.adc_dv = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.trig = 1'b0;
        set_cfg(1'b0, 1, 0);
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain run: 4 back-to-back samples, done one cycle after the last.
        set_cfg(1'b0, 1, 4);
        d0 = n_dv_seen; dn0 = n_done_seen;
        tick(1, 1, 0, 0);
        if (TRIG) tick(1, 0, 0, 1);
        repeat (8) tick(1, 0, 0, 0);
        chk("A_pulses", n_dv_seen - d0, 4);
        chk("A_done",   n_done_seen - dn0, 1);
        chk("A_cnt",    bus.cnt, 4);

        // Chop + dec=3: a pulse every 6 valids.
        set_cfg(1'b1, 3, 2);
        d0 = n_dv_seen; dn0 = n_done_seen;
        tick(1, 1, 0, 0);
        if (TRIG) tick(0, 0, 0, 1);
        repeat (16) tick(1, 0, 0, 0);
        chk("B_pulses", n_dv_seen - d0, 2);
        chk("B_done",   n_done_seen - dn0, 1);
        chk("B_cnt",    bus.cnt, 2);

        // Continuous, dec=0 treated as 1, stopped after 10 valids.
        set_cfg(1'b0, 0, 0);
        d0 = n_dv_seen; dn0 = n_done_seen;
        tick(0, 1, 0, 0);
        if (TRIG) tick(0, 0, 0, 1);
        repeat (10) tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0);
        chk("C_pulses", n_dv_seen - d0, 10);
        chk("C_done",   n_done_seen - dn0, 1);
        chk("C_cnt",    bus.cnt, 10);

        // start+stop in idle starts; start in run ignored; start+stop in run stops.
        set_cfg(1'b0, 1, 0);
        d0 = n_dv_seen; dn0 = n_done_seen;
        tick(1, 1, 1, 0);
        chk("D_busy", bus.busy, 1);
        if (TRIG) tick(1, 0, 0, 1);
        repeat (3) tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 1, 0);
        repeat (3) tick(0, 0, 0, 0);
        chk("D_pulses", n_dv_seen - d0, TRIG ? 5 : 4);
        chk("D_done",   n_done_seen - dn0, 1);

        // Stop coinciding with the final sample still emits it, one done.
        set_cfg(1'b0, 1, 2);
        d0 = n_dv_seen; dn0 = n_done_seen;
        tick(1, 1, 0, 0);
        if (TRIG) tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        repeat (3) tick(0, 0, 0, 0);
        chk("G_pulses", n_dv_seen - d0, 2);
        chk("G_done",   n_done_seen - dn0, 1);
        chk("G_cnt",    bus.cnt, 2);

        // Reset in the middle of a long run: everything clears, no done.
        set_cfg(1'b0, 1, 100);
        tick(1, 1, 0, 0);
        if (TRIG) tick(1, 0, 0, 1);
        repeat (5) tick(1, 0, 0, 0);
        chk("E_busy_before", bus.busy, 1);
        dn0 = n_done_seen;
        do_reset();
        repeat (3) tick(0, 0, 0, 0);
        chk("E_no_done", n_done_seen - dn0, 0);

`ifdef RP_DV_SCHED_TRIG_EN
        // Trigger gating, then abort while armed.
        set_cfg(1'b0, 1, 3);
        d0 = n_dv_seen;
        tick(1, 1, 0, 0);
        repeat (5) tick(1, 0, 0, 0);
        chk("F_no_dv_before_trig", n_dv_seen - d0, 0);
        chk("F_busy_armed", bus.busy, 1);
        tick(1, 0, 0, 1);
        repeat (5) tick(1, 0, 0, 0);
        chk("F_pulses", n_dv_seen - d0, 3);
        dn0 = n_done_seen;
        tick(0, 1, 0, 0);
        repeat (2) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        chk("F_arm_stop_cnt", bus.cnt, 0);
        tick(0, 0, 0, 0);
        chk("F_arm_stop_done", n_done_seen - dn0, 1);
`endif

        // Randomized runs; config is also scrambled while running.
        for (int r = 0; r < 60; r++) begin
            int stop_at;
            stop_at = $urandom_range(5, 40);
            set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6));
            tick(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
            for (int i = 0; i < 80 && m_state != 0; i++) begin
                bit sp;
                sp = ((m_len == '0) && (i == stop_at)) || ($urandom_range(0, 39) == 0);
                set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6));
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, sp,
                     TRIG && ($urandom_range(0, 4) == 0));
            end
            for (int k = 0; k < 4 && m_state != 0; k++) tick(0, 0, 1, 0);
            tick(0, 0, 0, 0);
        end

        repeat (3) tick(0, 0, 0, 0);
        chk("dv_queue_drained",   exp_dv.size(),   0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rp_dv_sched
